// File: rtl/macload_csr_arbiter.sv
// Arbitrates the single CSR write port between queued A- and W-address updates.
// Optional NN_ARB_FIXED_PRIO_EN: A always wins contention (no round-robin state).
module macload_csr_arbiter #(
  parameter int          PEND_DEPTH = 4,
  parameter logic [11:0] CSR_A_ADDR = 12'h7C0,
  parameter logic [11:0] CSR_W_ADDR = 12'h7C1,
  localparam int         PW         = $clog2(PEND_DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          update_a_i,
  input  logic          update_w_i,
  input  logic          ex_valid_i,
  input  logic          sw_csr_we_i,
  input  logic [11:0]   sw_csr_addr_i,
  output logic          grant_a_o,
  output logic          grant_w_o,
  output logic [1:0]    csr_op_o,
  output logic [11:0]   csr_address_o,
  output logic [PW-1:0] a_pend_o,
  output logic [PW-1:0] w_pend_o,
  output logic          stall_o,
  output logic          ovf_o
);
  localparam logic [1:0]    CSR_OP_NONE  = 2'b00;
  localparam logic [1:0]    CSR_OP_WRITE = 2'b01;
  localparam logic [PW-1:0] FULL         = PW'(PEND_DEPTH);

  logic [PW-1:0] a_pend_q, a_pend_d, w_pend_q, w_pend_d;
  logic          ovf_q, ovf_d;
  logic          req_a, req_w, grant_a, grant_w;
  logic          flush_a, flush_w, drop_a, drop_w;
`ifndef NN_ARB_FIXED_PRIO_EN
  logic          rr_q, rr_d;
`endif

  assign req_a   = update_a_i & ex_valid_i;
  assign req_w   = update_w_i & ex_valid_i;
  assign flush_a = sw_csr_we_i & (sw_csr_addr_i == CSR_A_ADDR);
  assign flush_w = sw_csr_we_i & (sw_csr_addr_i == CSR_W_ADDR);

  // A software write owns the port, so no queued update may be granted that cycle.
  always_comb begin
    grant_a = 1'b0;
    grant_w = 1'b0;
    if (!sw_csr_we_i) begin
      if (a_pend_q != '0 && w_pend_q != '0) begin
`ifdef NN_ARB_FIXED_PRIO_EN
        grant_a = 1'b1;
`else
        grant_w = rr_q;
        grant_a = ~rr_q;
`endif
      end else if (a_pend_q != '0) begin
        grant_a = 1'b1;
      end else if (w_pend_q != '0) begin
        grant_w = 1'b1;
      end
    end
  end

  // A flush replaces the queue with this cycle's request, so that request is never dropped.
  always_comb begin
    drop_a   = req_a & (a_pend_q == FULL) & ~grant_a & ~flush_a;
    drop_w   = req_w & (w_pend_q == FULL) & ~grant_w & ~flush_w;
    a_pend_d = flush_a ? PW'(req_a)
                       : a_pend_q + PW'(req_a & ~drop_a) - PW'(grant_a);
    w_pend_d = flush_w ? PW'(req_w)
                       : w_pend_q + PW'(req_w & ~drop_w) - PW'(grant_w);
    ovf_d    = ovf_q | drop_a | drop_w;
`ifndef NN_ARB_FIXED_PRIO_EN
    rr_d = rr_q;
    if (grant_a) rr_d = 1'b1;
    if (grant_w) rr_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_pend_q <= '0;
      w_pend_q <= '0;
      ovf_q    <= 1'b0;
`ifndef NN_ARB_FIXED_PRIO_EN
      rr_q     <= 1'b0;
`endif
    end else begin
      a_pend_q <= a_pend_d;
      w_pend_q <= w_pend_d;
      ovf_q    <= ovf_d;
`ifndef NN_ARB_FIXED_PRIO_EN
      rr_q     <= rr_d;
`endif
    end
  end

  // Outputs are held at zero for the whole reset cycle, before state has cleared.
  always_comb begin
    grant_a_o     = grant_a & ~rst_i;
    grant_w_o     = grant_w & ~rst_i;
    csr_op_o      = (grant_a_o | grant_w_o) ? CSR_OP_WRITE : CSR_OP_NONE;
    csr_address_o = grant_a_o ? CSR_A_ADDR : (grant_w_o ? CSR_W_ADDR : 12'h000);
    a_pend_o      = rst_i ? '0 : a_pend_q;
    w_pend_o      = rst_i ? '0 : w_pend_q;
    stall_o       = ~rst_i & ((a_pend_q == FULL) | (w_pend_q == FULL));
    ovf_o         = ~rst_i & ovf_q;
  end
endmodule
